// File: rtl/lsu.sv
// rtl/lsu.sv - Load/store unit: a RISC-V byte/half/word access FSM with read-modify-write for SB and SH.
// Optional alignment checking is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu #(
  parameter int EXT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [EXT_WIDTH-1:0] req_addr,
  input  logic [EXT_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [EXT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [EXT_WIDTH-1:0] mem_A,
  output logic [EXT_WIDTH-1:0] mem_WD,
  output logic                 mem_WE,
  input  logic [EXT_WIDTH-1:0] mem_RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                 state, state_nx;
  logic                   we_q;
  logic [2:0]             f3_q;
  logic [EXT_WIDTH-1:0]   addr_q, wdata_q, rdata_q;
  logic [EXT_WIDTH-1:8]   rd_hi_q;
  logic                   err_q;
  logic                   code_ok, misalign, bad, accept;
  logic [EXT_WIDTH-1:0]   store_word;

  function automatic logic [EXT_WIDTH-1:0] load_fmt(input logic [2:0] f3,
                                                    input logic [EXT_WIDTH-1:0] w);
    case (f3)
      3'b000:  load_fmt = {{(EXT_WIDTH-8){w[7]}}, w[7:0]};
      3'b100:  load_fmt = {{(EXT_WIDTH-8){1'b0}}, w[7:0]};
      3'b001:  load_fmt = {{(EXT_WIDTH-16){w[15]}}, w[15:0]};
      3'b101:  load_fmt = {{(EXT_WIDTH-16){1'b0}}, w[15:0]};
      default: load_fmt = w;
    endcase
  endfunction

  always_comb begin
    if (req_we) code_ok = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
    else        code_ok = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    bad    = !code_ok || misalign;
    accept = (state == IDLE) && req_valid;
  end

  // SB/SH merge the new low lane(s) into the word captured during READ.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   store_word = {rd_hi_q[EXT_WIDTH-1:8], wdata_q[7:0]};
      2'b01:   store_word = {rd_hi_q[EXT_WIDTH-1:16], wdata_q[15:0]};
      default: store_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_A      = '0;
    mem_WD     = '0;
    mem_WE     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                                   state_nx = RESP;
          else if (!req_we || req_funct3 != 3'b010)  state_nx = READ;
          else                                       state_nx = WRITE;
        end
      end
      READ: begin
        mem_A    = addr_q;
        state_nx = we_q ? WRITE : RESP;
      end
      WRITE: begin
        mem_A    = addr_q;
        mem_WE   = 1'b1;
        mem_WD   = store_word;
        state_nx = RESP;
      end
      RESP: begin
        mem_A      = addr_q;
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_hi_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= bad;
        rdata_q <= '0;
      end
      if (state == READ) begin
        rd_hi_q <= mem_RD[EXT_WIDTH-1:8];
        if (!we_q) rdata_q <= load_fmt(f3_q, mem_RD);
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - Randomized self-checking bench for lsu against a byte-array reference model.
// Define LSU_MISALIGN_CHECK_EN consistently for bench and design to cover the alignment check.
module tb_lsu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we;
  logic [2:0]   req_funct3;
  logic [W-1:0] req_addr, req_wdata;
  logic         resp_valid, resp_err, mem_WE;
  logic [W-1:0] resp_rdata, mem_A, mem_WD, mem_RD;

  lsu #(.EXT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];

  assign mem_RD = {env_mem[mem_A[7:0] + 8'd3], env_mem[mem_A[7:0] + 8'd2],
                   env_mem[mem_A[7:0] + 8'd1], env_mem[mem_A[7:0]]};

  always @(posedge clk) begin
    if (mem_WE) begin
      env_mem[mem_A[7:0]]        <= mem_WD[7:0];
      env_mem[mem_A[7:0] + 8'd1] <= mem_WD[15:8];
      env_mem[mem_A[7:0] + 8'd2] <= mem_WD[23:16];
      env_mem[mem_A[7:0] + 8'd3] <= mem_WD[31:24];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding operation, described by its cycle schedule.
  bit          busy = 1'b0;
  int          cyc, lat, wr_cyc;
  logic [31:0] e_rdata, e_wd, op_addr;
  bit          e_err;

  task automatic model_accept(input bit we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    int ai, v;
    bit valid, mis;
    logic [31:0] w;
    ai = int'(a[7:0]);
    w  = {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
    valid = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
    if (f3[1:0] == 2'd1 && (a % 2) != 0) mis = 1'b1;
    if (f3[1:0] == 2'd2 && (a % 4) != 0) mis = 1'b1;
`endif
    busy = 1'b1; cyc = 0; op_addr = a; e_err = 1'b0; e_rdata = 0; wr_cyc = 0; e_wd = 0;
    if (!valid || mis) begin
      lat = 1; e_err = 1'b1;
    end else if (!we) begin
      lat = 2;
      case (f3)
        3'd0: begin v = int'(w & 32'hFF);   if (v >= 128)   v -= 256;   e_rdata = 32'(v); end
        3'd4: e_rdata = w & 32'hFF;
        3'd1: begin v = int'(w & 32'hFFFF); if (v >= 32768) v -= 65536; e_rdata = 32'(v); end
        3'd5: e_rdata = w & 32'hFFFF;
        default: e_rdata = w;
      endcase
    end else if (f3 == 3'd2) begin
      lat = 2; wr_cyc = 1; e_wd = wd;
    end else begin
      lat = 3; wr_cyc = 2;
      e_wd = (f3 == 3'd0) ? ((w & ~32'hFF) | (wd & 32'hFF)) : ((w & ~32'hFFFF) | (wd & 32'hFFFF));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_err", 32'(resp_err), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_we", 32'(mem_WE), 32'd0);
      chk("rst_addr", mem_A, 32'd0);
      chk("rst_wd", mem_WD, 32'd0);
    end else begin
      if (busy) begin
        cyc++;
        if (cyc > lat) busy = 1'b0;
      end
      if (busy) begin
        chk("busy_ready", 32'(req_ready), 32'd0);
        chk("resp_valid", 32'(resp_valid), 32'(cyc == lat));
        chk("mem_WE", 32'(mem_WE), 32'(cyc == wr_cyc));
        chk("mem_WD", mem_WD, (cyc == wr_cyc) ? e_wd : 32'd0);
        chk("mem_A", mem_A, op_addr);
        if (cyc == lat) begin
          chk("resp_rdata", resp_rdata, e_rdata);
          chk("resp_err", 32'(resp_err), 32'(e_err));
        end
        if (cyc == wr_cyc) begin
          for (int k = 0; k < 4; k++) ref_mem[int'(op_addr[7:0]) + k] = 8'(e_wd >> (8 * k));
        end
      end else begin
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_valid", 32'(resp_valid), 32'd0);
        chk("idle_we", 32'(mem_WE), 32'd0);
        chk("idle_wd", mem_WD, 32'd0);
      end
      if (!busy && req_valid) model_accept(req_we, req_funct3, req_addr, req_wdata);
    end
  end

  task automatic do_op(input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bit ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int exp_lat, input logic [31:0] exp_rd,
                           input bit exp_err, output logic [31:0] wd_seen, output int we_cnt);
    bit got = 1'b0;
    we_cnt = 0; wd_seen = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (mem_WE) begin we_cnt++; wd_seen = mem_WD; end
      if (resp_valid) begin
        chk({name, "_lat"}, 32'(i), 32'(exp_lat));
        chk({name, "_rdata"}, resp_rdata, exp_rd);
        chk({name, "_err"}, 32'(resp_err), 32'(exp_err));
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic [31:0] wd_seen;
  int          we_cnt;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    for (int i = 0; i < 6; i++) begin
      env_mem[16+i] = 8'(48'h0000_1234_FF80 >> (8 * i));
      ref_mem[16+i] = env_mem[16+i];
    end
    #1;
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    chk("async_rst_addr", mem_A, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    do_op(0, 3'b000, 32'h10, 0); wait_resp("lb", 2, 32'hFFFF_FF80, 0, wd_seen, we_cnt);
    do_op(0, 3'b100, 32'h10, 0); wait_resp("lbu", 2, 32'h0000_0080, 0, wd_seen, we_cnt);
    do_op(0, 3'b001, 32'h10, 0); wait_resp("lh", 2, 32'hFFFF_FF80, 0, wd_seen, we_cnt);
    do_op(0, 3'b010, 32'h10, 0); wait_resp("lw", 2, 32'h1234_FF80, 0, wd_seen, we_cnt);
    do_op(1, 3'b000, 32'h11, 32'h0000_00AA); wait_resp("sb", 3, 32'h0, 0, wd_seen, we_cnt);
    chk("sb_wd", wd_seen, 32'h0012_34AA);
    chk("sb_we_cnt", 32'(we_cnt), 32'd1);
    @(posedge clk); #1;
    do_op(0, 3'b010, 32'h10, 0); wait_resp("lw_after_sb", 2, 32'h1234_AA80, 0, wd_seen, we_cnt);
`ifdef LSU_MISALIGN_CHECK_EN
    do_op(0, 3'b010, 32'h12, 0); wait_resp("lw_mis", 1, 32'h0, 1, wd_seen, we_cnt);
`else
    do_op(0, 3'b010, 32'h12, 0); wait_resp("lw_mis", 2, 32'h0000_1234, 0, wd_seen, we_cnt);
`endif
    chk("lw_mis_we_cnt", 32'(we_cnt), 32'd0);
    do_op(0, 3'b011, 32'h10, 0); wait_resp("bad_code", 1, 32'h0, 1, wd_seen, we_cnt);
    chk("bad_code_we_cnt", 32'(we_cnt), 32'd0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      do_op(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom);
    end
    repeat (5) @(posedge clk);
    #1;

    do_op(1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    #1;
    chk("sw_we_active", 32'(mem_WE), 32'd1);
    rst = 1'b1;
    #1;
    chk("midwr_we", 32'(mem_WE), 32'd0);
    chk("midwr_ready", 32'(req_ready), 32'd1);
    chk("midwr_valid", 32'(resp_valid), 32'd0);
    chk("midwr_wd", mem_WD, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end
    for (int k = 0; k < 4; k++) chk("sw_dropped_mem", 32'(env_mem[32+k]), 32'(ref_mem[32+k]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter EXT_WIDTH, default 32: width of address, data and response buses.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline presents a memory operation.
REQ-005 req_ready  output  1  lsu accepts an operation this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V size code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-008 req_addr  input  EXT_WIDTH  byte address.
REQ-009 req_wdata  input  EXT_WIDTH  store data, right-justified.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  EXT_WIDTH  formatted load result; 0 for stores and errors.
REQ-012 resp_err  output  1  operation rejected, valid only with resp_valid.
REQ-013 mem_A  output  EXT_WIDTH  byte address to data memory; memory returns bytes A..A+3, little-endian.
REQ-014 mem_WD  output  EXT_WIDTH  word written to bytes A..A+3.
REQ-015 mem_WE  output  1  memory write enable, sampled at rising clk.
REQ-016 mem_RD  input  EXT_WIDTH  combinational read data for current mem_A.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 On req_valid&&req_ready the lsu SHALL latch we, funct3, addr and wdata; req_valid is ignored outside IDLE.
REQ-019 Accepted transitions: load -> READ; SW -> WRITE; SB/SH -> READ; invalid code (load 011/110/111, store funct3 other than 000/001/010) -> RESP with err.
REQ-020 READ lasts one cycle, mem_A = latched addr, mem_RD captured at its end; load -> RESP, SB/SH -> WRITE.
REQ-021 WRITE lasts one cycle with mem_WE=1, mem_A = latched addr; next state RESP.
REQ-022 SW mem_WD = wdata; SB mem_WD = {captured[31:8], wdata[7:0]}; SH mem_WD = {captured[31:16], wdata[15:0]}.
REQ-023 Load formatting of captured word: LB sign-extends [7:0], LBU zero-extends [7:0], LH sign-extends [15:0], LHU zero-extends [15:0], LW passes all 32 bits.
REQ-024 RESP lasts one cycle: resp_valid=1, resp_rdata/resp_err driven from registers, then IDLE.
REQ-025 Outside WRITE mem_WE SHALL be 0; mem_A SHALL hold latched addr in all non-IDLE states; mem_WD SHALL be 0 outside WRITE.
REQ-026 Latency from accept edge to resp_valid: LB/LH/LW/LBU/LHU and SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
REQ-027 Back-to-back: a new request SHALL be acceptable in the cycle after RESP (IDLE); throughput one operation per 3-4 cycles.
REQ-028 Errored operations SHALL never assert mem_WE.

Reset
REQ-029 rst SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_WE=0, mem_A=0, mem_WD=0, independent of clk.
REQ-030 Reset mid-operation SHALL drop the operation with no response; a reset asserted during WRITE SHALL deassert mem_WE before the next rising edge.

Configuration
REQ-031 Macro LSU_MISALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=00, SHALL go IDLE -> RESP with resp_err=1 and no memory access.
REQ-032 Macro undefined: no alignment check; any address proceeds as a normal access, resp_err only for invalid size codes.

Verification
REQ-033 Memory bytes 0x10..0x13 = 80 FF 34 12; LB 0x10 -> resp_rdata 0xFFFFFF80 two cycles after accept; LBU 0x10 -> 0x00000080.
REQ-034 LH 0x10 -> 0xFFFFFF80; LW 0x10 -> 0x1234FF80, resp_err=0.
REQ-035 SB addr 0x11 data 0xAA with bytes 0x11..0x14 = FF 34 12 00 -> READ, WRITE (mem_WD 0x001234AA, mem_WE one cycle), resp 3 cycles after accept; subsequent LW 0x10 -> 0x1234AA80.
REQ-036 With LSU_MISALIGN_CHECK_EN: LW 0x12 -> resp_err=1 one cycle after accept, mem_WE never 1; without macro -> normal data, err=0.
REQ-037 Load funct3 011 -> resp_err=1, resp_rdata 0.
REQ-038 SW 0x20 data 0xDEADBEEF, rst asserted mid-WRITE -> mem_WE drops immediately, no resp_valid, req_ready=1.
